// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and codes for the pulse-parameter UART link.
// Both the receive decoder and the readback transmitter import this.
package pulse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_START,
    WAIT_END
  } state_t;

  localparam int DATA_BYTES = 4;

  // Readback word index map
  localparam int IDX_DELAY   = 0;
  localparam int IDX_PERIOD  = 1;
  localparam int IDX_P1WIDTH = 2;
  localparam int IDX_P2WIDTH = 3;
  localparam int IDX_PBWIDTH = 4;
  localparam int IDX_CTRL    = 5;
  localparam int IDX_ATTEN   = 6;
  localparam int IDX_SYNC_UP = 7;

  // Receive-side control-byte codes, numbered to match the index map
  localparam logic [7:0] CMD_DELAY   = 8'h00;
  localparam logic [7:0] CMD_PERIOD  = 8'h01;
  localparam logic [7:0] CMD_P1WIDTH = 8'h02;
  localparam logic [7:0] CMD_P2WIDTH = 8'h03;
  localparam logic [7:0] CMD_PBWIDTH = 8'h04;
  localparam logic [7:0] CMD_CTRL    = 8'h05;
  localparam logic [7:0] CMD_ATTEN   = 8'h06;
  localparam logic [7:0] CMD_SYNC_UP = 8'h07;
  localparam logic [7:0] CMD_READ    = 8'h08;

endpackage

// File: rtl/pulse_report.sv
// pulse_report: snapshots one parameter word and sends it LSB-first.
// Define PULSE_REPORT_CHECKSUM_EN to append an 8-bit sum byte.
import pulse_pkg::*;

module pulse_report #(
  parameter int NWORDS = 8,
  parameter int SELW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWORDS*32-1:0] words,
  input  logic                 req,
  input  logic [SELW-1:0]      sel,
  input  logic                 is_transmitting,
  output logic                 transmit,
  output logic [7:0]           tx_byte,
  output logic                 busy,
  output logic                 done,
  output logic                 sel_err
);

`ifdef PULSE_REPORT_CHECKSUM_EN
  localparam int FRAME_BYTES = DATA_BYTES + 1;
`else
  localparam int FRAME_BYTES = DATA_BYTES;
`endif

  localparam logic [2:0] LAST = 3'(FRAME_BYTES - 1);
  localparam logic [SELW:0] NW = (SELW+1)'(NWORDS);

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  tx_q, tx_d;
  logic [2:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        strobe_q, strobe_d;
  logic        in_range;
`ifdef PULSE_REPORT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign in_range = {1'b0, sel} < NW;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    err_d    = err_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;
`ifdef PULSE_REPORT_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (in_range) begin
            shadow_d = words[{sel, 5'd0} +: 32];
            err_d    = 1'b0;
          end else begin
            shadow_d = '0;
            err_d    = 1'b1;
          end
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
`ifdef PULSE_REPORT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
`ifdef PULSE_REPORT_CHECKSUM_EN
        tx_d = (idx_q < 3'(DATA_BYTES))
             ? shadow_q[{idx_q[1:0], 3'd0} +: 8]
             : csum_q;
`else
        tx_d = shadow_q[{idx_q[1:0], 3'd0} +: 8];
`endif
        state_d = STROBE;
      end
      STROBE: begin
        if (!is_transmitting) begin
          strobe_d = 1'b1;
          state_d  = WAIT_START;
        end
      end
      WAIT_START: begin
        if (is_transmitting) state_d = WAIT_END;
      end
      WAIT_END: begin
        if (!is_transmitting) begin
`ifdef PULSE_REPORT_CHECKSUM_EN
          if (idx_q < 3'(DATA_BYTES)) csum_d = csum_q + tx_q;
`endif
          if (idx_q == LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      tx_q     <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef PULSE_REPORT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  assign transmit = strobe_q;
  assign tx_byte  = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_err  = err_q;

endmodule
